// File: rtl/sam_pkg.sv
// Shared SAM link definitions: transmitter state encoding, header width and
// the length-exponent clamp used by both ends of the link.
package sam_pkg;

    localparam int SAM_N_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        CFG_N,
        CFG_D,
        CFG_C,
        DATA_ONES,
        DATA_ZEROS,
        TRAILER
    } sam_state_e;

    function automatic logic [SAM_N_BITS-1:0] sam_clamp(
        input logic [SAM_N_BITS-1:0] n,
        input int unsigned           max_log2
    );
        if (32'(n) > max_log2) begin
            return SAM_N_BITS'(max_log2);
        end
        return n;
    endfunction

endpackage

// File: rtl/sam_tx_if.sv
// Host-side bundle of the SAM transmitter: frame request, payload fields and
// the serial line/status outputs.
interface sam_tx_if #(
    parameter int MAX_LOG2 = 3
);
    import sam_pkg::*;

    localparam int W = 1 << MAX_LOG2;

    logic                  start;
    logic [SAM_N_BITS-1:0] len_log2;
    logic [W-1:0]          cfg_d;
    logic [W-1:0]          cfg_c;
    logic [W-1:0]          msg_in;
    logic                  str;
    logic                  mode;
    logic                  busy;
    logic                  done;

    modport master (
        output start, len_log2, cfg_d, cfg_c, msg_in,
        input  str, mode, busy, done
    );

    modport slave (
        input  start, len_log2, cfg_d, cfg_c, msg_in,
        output str, mode, busy, done
    );

endinterface

// File: rtl/sam_sym_gen.sv
// Width-coded symbol generator: a run of ones then a run of zeros, long/short
// for bit 1 and short/long for bit 0. A new sym_start may land on sym_done.
module sam_sym_gen #(
    parameter int LONG_LEN  = 12,
    parameter int SHORT_LEN = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic sym_start,
    input  logic sym_bit,
    output logic str,
    output logic sym_done
);
    localparam int RUN_W = $clog2(LONG_LEN + 1);
    localparam logic [RUN_W-1:0] LONG_M1  = RUN_W'(LONG_LEN - 1);
    localparam logic [RUN_W-1:0] SHORT_M1 = RUN_W'(SHORT_LEN - 1);

    logic             active_reg;
    logic             ones_reg;
    logic             bit_reg;
    logic [RUN_W-1:0] run_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg <= 1'b0;
            ones_reg   <= 1'b0;
            bit_reg    <= 1'b0;
            run_reg    <= '0;
        end else if (sym_start) begin
            active_reg <= 1'b1;
            ones_reg   <= 1'b1;
            bit_reg    <= sym_bit;
            run_reg    <= sym_bit ? LONG_M1 : SHORT_M1;
        end else if (active_reg) begin
            if (run_reg != '0) begin
                run_reg <= run_reg - RUN_W'(1);
            end else if (ones_reg) begin
                ones_reg <= 1'b0;
                run_reg  <= bit_reg ? SHORT_M1 : LONG_M1;
            end else begin
                active_reg <= 1'b0;
            end
        end
    end

    assign str      = ones_reg;
    // Last cycle of the zeros run: the caller may chain the next symbol here.
    assign sym_done = active_reg && !ones_reg && (run_reg == '0);

endmodule

// File: rtl/sam_tx.sv
// SAM link transmitter: header, D and C config fields with mode=1, then a
// width-coded message and a one-cycle trailer. SAM_TX_PARITY_EN appends an even-parity symbol.
module sam_tx
    import sam_pkg::*;
#(
    parameter int MAX_LOG2  = 3,
    parameter int LONG_LEN  = 12,
    parameter int SHORT_LEN = 6
) (
    input  logic     clk,
    input  logic     reset,
    sam_tx_if.slave  bus
);
    localparam int W     = 1 << MAX_LOG2;
    localparam int IDX_W = MAX_LOG2 + 1;

    generate
        if (!(LONG_LEN > SHORT_LEN && SHORT_LEN >= 1 &&
              LONG_LEN + SHORT_LEN >= 10 && LONG_LEN + SHORT_LEN <= 60)) begin : g_bad_len
            $error("sam_tx: symbol run lengths out of range");
        end
        if (MAX_LOG2 < 1 || MAX_LOG2 > 15) begin : g_bad_log2
            $error("sam_tx: MAX_LOG2 out of range");
        end
    endgenerate

    sam_state_e            state_reg;
    logic [SAM_N_BITS-1:0] n_reg;
    logic [W-1:0]          d_reg;
    logic [W-1:0]          c_reg;
    logic [W-1:0]          msg_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  str_reg;
    logic                  mode_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic [SAM_N_BITS-1:0] n_eff;
    logic [IDX_W-1:0]      idx_m1;
    logic [IDX_W-1:0]      l_m1;
    logic                  in_data;
    logic                  sym_start;
    logic                  sym_bit;
    logic                  sym_str;
    logic                  sym_done;

    assign n_eff   = sam_clamp(bus.len_log2, MAX_LOG2);
    assign idx_m1  = idx_reg - IDX_W'(1);
    assign l_m1    = IDX_W'((32'd1 << n_reg) - 32'd1);
    assign in_data = (state_reg == DATA_ONES) || (state_reg == DATA_ZEROS);

`ifdef SAM_TX_PARITY_EN
    logic [W-1:0] len_mask;
    logic         parity_reg;
    logic         par_sent_reg;

    for (genvar gi = 0; gi < W; gi++) begin : g_mask
        assign len_mask[gi] = (gi < (32'd1 << n_eff));
    end
`endif

    always_comb begin
        sym_start = 1'b0;
        sym_bit   = 1'b0;
        if (state_reg == CFG_C && idx_reg == '0) begin
            sym_start = 1'b1;
            sym_bit   = msg_reg[l_m1[MAX_LOG2-1:0]];
        end else if (in_data && sym_done && idx_reg != '0) begin
            sym_start = 1'b1;
            sym_bit   = msg_reg[idx_m1[MAX_LOG2-1:0]];
        end
`ifdef SAM_TX_PARITY_EN
        else if (in_data && sym_done && !par_sent_reg) begin
            sym_start = 1'b1;
            sym_bit   = parity_reg;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            d_reg     <= '0;
            c_reg     <= '0;
            msg_reg   <= '0;
            idx_reg   <= '0;
            str_reg   <= 1'b0;
            mode_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SAM_TX_PARITY_EN
            parity_reg   <= 1'b0;
            par_sent_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    str_reg  <= 1'b0;
                    mode_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (bus.start) begin
                        state_reg <= CFG_N;
                        n_reg     <= n_eff;
                        d_reg     <= bus.cfg_d;
                        c_reg     <= bus.cfg_c;
                        msg_reg   <= bus.msg_in;
                        idx_reg   <= IDX_W'(SAM_N_BITS - 1);
                        str_reg   <= n_eff[SAM_N_BITS-1];
                        mode_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
`ifdef SAM_TX_PARITY_EN
                        parity_reg   <= ^(bus.msg_in & len_mask);
                        par_sent_reg <= 1'b0;
`endif
                    end
                end
                CFG_N: begin
                    if (idx_reg == '0) begin
                        state_reg <= CFG_D;
                        idx_reg   <= l_m1;
                        str_reg   <= d_reg[l_m1[MAX_LOG2-1:0]];
                    end else begin
                        idx_reg <= idx_m1;
                        str_reg <= n_reg[idx_m1[1:0]];
                    end
                end
                CFG_D: begin
                    if (idx_reg == '0) begin
                        state_reg <= CFG_C;
                        idx_reg   <= l_m1;
                        str_reg   <= c_reg[l_m1[MAX_LOG2-1:0]];
                    end else begin
                        idx_reg <= idx_m1;
                        str_reg <= d_reg[idx_m1[MAX_LOG2-1:0]];
                    end
                end
                CFG_C: begin
                    if (idx_reg == '0) begin
                        // sym_start fires this cycle with the message MSB.
                        state_reg <= DATA_ONES;
                        idx_reg   <= l_m1;
                        str_reg   <= 1'b0;
                        mode_reg  <= 1'b0;
                    end else begin
                        idx_reg <= idx_m1;
                        str_reg <= c_reg[idx_m1[MAX_LOG2-1:0]];
                    end
                end
                DATA_ONES, DATA_ZEROS: begin
                    if (sym_done) begin
                        if (sym_start) begin
                            state_reg <= DATA_ONES;
                            if (idx_reg != '0) begin
                                idx_reg <= idx_m1;
                            end
`ifdef SAM_TX_PARITY_EN
                            else begin
                                par_sent_reg <= 1'b1;
                            end
`endif
                        end else begin
                            state_reg <= TRAILER;
                            str_reg   <= 1'b1;
                        end
                    end else if (!sym_str) begin
                        state_reg <= DATA_ZEROS;
                    end
                end
                TRAILER: begin
                    state_reg <= IDLE;
                    str_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    str_reg   <= 1'b0;
                    mode_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    sam_sym_gen #(
        .LONG_LEN  (LONG_LEN),
        .SHORT_LEN (SHORT_LEN)
    ) u_sym_gen (
        .clk       (clk),
        .reset     (reset),
        .sym_start (sym_start),
        .sym_bit   (sym_bit),
        .str       (sym_str),
        .sym_done  (sym_done)
    );

    // During data symbols the line follows the generator's registered run.
    assign bus.str  = in_data ? sym_str : str_reg;
    assign bus.mode = mode_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

// File: tb/tb_sam_tx.sv
// Self-checking bench for sam_tx: directed and random frames compared cycle by
// cycle against a waveform model built from the link's encoding rules.
module tb_sam_tx;
    localparam int MAX_LOG2 = 3;
    localparam int W        = 1 << MAX_LOG2;
    localparam int LONG     = 12;
    localparam int SHORT    = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sam_tx_if #(.MAX_LOG2(MAX_LOG2)) bus ();

    sam_tx #(
        .MAX_LOG2  (MAX_LOG2),
        .LONG_LEN  (LONG),
        .SHORT_LEN (SHORT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_str[$];
    bit exp_mode[$];

    task automatic check(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    endtask

    task automatic emit(input bit s, input bit md, input int count);
        for (int i = 0; i < count; i++) begin
            exp_str.push_back(s);
            exp_mode.push_back(md);
        end
    endtask

    task automatic emit_symbol(input bit b);
        emit(1'b1, 1'b0, b ? LONG : SHORT);
        emit(1'b0, 1'b0, b ? SHORT : LONG);
    endtask

    // Expected (str, mode) for every busy cycle of one frame.
    task automatic build_model(input logic [3:0] lenl, input logic [W-1:0] d,
                               input logic [W-1:0] c, input logic [W-1:0] m);
        int n;
        int len;
        bit par;
        exp_str.delete();
        exp_mode.delete();
        n   = (int'(lenl) > MAX_LOG2) ? MAX_LOG2 : int'(lenl);
        len = 1 << n;
        for (int i = 3; i >= 0; i--) emit(n[i], 1'b1, 1);
        for (int i = len - 1; i >= 0; i--) emit(d[i], 1'b1, 1);
        for (int i = len - 1; i >= 0; i--) emit(c[i], 1'b1, 1);
        par = 1'b0;
        for (int i = len - 1; i >= 0; i--) begin
            emit_symbol(m[i]);
            par ^= m[i];
        end
`ifdef SAM_TX_PARITY_EN
        emit_symbol(par);
`endif
        emit(1'b1, 1'b0, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".str"},  bus.str,  1'b0);
        check({tag, ".mode"}, bus.mode, 1'b0);
        check({tag, ".busy"}, bus.busy, 1'b0);
        check({tag, ".done"}, bus.done, 1'b0);
    endtask

    task automatic idle_cycles(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check_idle(tag);
        end
    endtask

    task automatic scramble_inputs();
        bus.len_log2 = 4'($urandom);
        bus.cfg_d    = W'($urandom);
        bus.cfg_c    = W'($urandom);
        bus.msg_in   = W'($urandom);
    endtask

    // poke_at: busy-cycle index where start is re-pulsed; abort_at: where reset hits.
    task automatic run_frame(input string name, input logic [3:0] lenl,
                             input logic [W-1:0] d, input logic [W-1:0] c,
                             input logic [W-1:0] m, input int poke_at, input int abort_at);
        int nexp;
        build_model(lenl, d, c, m);
        nexp = exp_str.size();
        $display("frame %s: len_log2=%0d d=%h c=%h msg=%h expected busy=%0d",
                 name, lenl, d, c, m, nexp);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.len_log2 = lenl;
        bus.cfg_d    = d;
        bus.cfg_c    = c;
        bus.msg_in   = m;
        @(posedge clk); #1;
        scramble_inputs();
        for (int k = 0; k < nexp; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
            check($sformatf("%s.str[%0d]", name, k),  bus.str,  exp_str[k]);
            check($sformatf("%s.mode[%0d]", name, k), bus.mode, exp_mode[k]);
            check($sformatf("%s.busy[%0d]", name, k), bus.busy, 1'b1);
            check($sformatf("%s.done[%0d]", name, k), bus.done, 1'b0);
            if (k == poke_at) begin
                bus.start = 1'b1;
                scramble_inputs();
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check_idle({name, ".abort"});
                idle_cycles(nexp, {name, ".after_abort"});
                return;
            end
        end
        @(posedge clk); #1;
        check({name, ".end.done"}, bus.done, 1'b1);
        check({name, ".end.busy"}, bus.busy, 1'b0);
        check({name, ".end.str"},  bus.str,  1'b0);
        check({name, ".end.mode"}, bus.mode, 1'b0);
        @(posedge clk); #1;
        check({name, ".post.done"}, bus.done, 1'b0);
        check({name, ".post.busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.len_log2 = '0;
        bus.cfg_d    = '0;
        bus.cfg_c    = '0;
        bus.msg_in   = '0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        idle_cycles(5, "idle");

        run_frame("n1", 4'd1, W'(8'b10), W'(8'b01), W'(8'b10), -1, -1);
        idle_cycles(2, "gap");
        run_frame("n0", 4'd0, W'(8'b1), W'(8'b0), W'(8'b0), -1, -1);
        run_frame("clamp9", 4'd9, W'(8'hA5), W'(8'h3C), W'(8'hC9), -1, -1);
        run_frame("n2", 4'd2, W'(8'h6), W'(8'h9), W'(8'hB), -1, -1);
        run_frame("poke", 4'd1, W'(8'h2), W'(8'h1), W'(8'h1), -1 + 21, -1);
        idle_cycles(3, "after_poke");
        run_frame("abort", 4'd2, W'(8'hF), W'(8'h5), W'(8'hA), -1, 5);

        for (int r = 0; r < 6; r++) begin
            run_frame($sformatf("rand%0d", r), 4'($urandom_range(0, 15)),
                      W'($urandom), W'($urandom), W'($urandom), -1, -1);
            idle_cycles(int'($urandom_range(0, 3)), "rand_gap");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
